// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and the parity function
// used by both the transmit framer and the receive path.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   function automatic logic uart_parity(input logic [DATA_BITS-1:0] data, input logic odd_sel);
      return odd_sel ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// Zero latency on bit_tick_o; clr_i holds the count at zero, no backpressure.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic bit_tick_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || bit_tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB-first, optional parity, 1-2 stop bits.
// tx is registered (low on the accepting edge); tx_ready only while idle, no queuing.
module uart_tx_frame import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 bit_tick;
   logic                 accept;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q == IDLE),
      .bit_tick_o(bit_tick)
   );

   assign tx_ready = (state_q == IDLE);
   assign busy     = !tx_ready;
   assign tx       = tx_q;
   assign tx_done  = done_q;
   assign accept   = tx_valid && tx_ready;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      data_d     = data_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               shift_d    = tx_data;
               data_d     = tx_data;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level follows the state being entered so tx is a clean register.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = uart_parity(data_q, PARITY_ODD != 0);
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         data_q     <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four framer configurations run in lock-step and a
// per-cycle line monitor scores every frame against the bytes offered to it.
module tb_uart_tx_frame;

   localparam int C = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] dat_r  [4];
   logic       vld_r  [4];
   logic       tx_w   [4];
   logic       rdy_w  [4];
   logic       busy_w [4];
   logic       done_w [4];

   int applied     = 0;
   int miscompares = 0;

   logic [7:0]  stim_list [$];
   logic [7:0]  exp_q [4][$];
   int          sp [4], cyc [4], frames [4], done_cnt [4];
   int          start_cyc [4], period [4], lowcnt [4], lastlow [4];
   bit          mact [4], presenting [4], prev_ok [4];
   logic [11:0] fbits [4];
   bit          inj = 1'b0;
   int          cycle = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_frame #(
         .CLKS_PER_BIT(C),
         .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
         .PARITY_ODD  ((g == 2) ? 1 : 0),
         .STOP_BITS   ((g == 3) ? 2 : 1)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .tx_data (dat_r[g]),
         .tx_valid(vld_r[g]),
         .tx_ready(rdy_w[g]),
         .tx      (tx_w[g]),
         .busy    (busy_w[g]),
         .tx_done (done_w[g])
      );
   end

   function automatic int pe_of(int k);
      return (k == 1 || k == 2) ? 1 : 0;
   endfunction

   function automatic int po_of(int k);
      return (k == 2) ? 1 : 0;
   endfunction

   function automatic int frame_len(int k);
      return (9 + pe_of(k) + ((k == 3) ? 2 : 1)) * C;
   endfunction

   function automatic logic par_of(int k, logic [7:0] b);
      return (po_of(k) != 0) ? ~^b : ^b;
   endfunction

   function automatic int low_expect(int k, logic [7:0] b);
      int zeros;
      zeros = 8 - $countones(b);
      return C * (1 + zeros + ((pe_of(k) != 0 && par_of(k, b) == 1'b0) ? 1 : 0));
   endfunction

   // Line monitor and handshake driver, one pass per DUT on every falling edge.
   initial begin
      logic [7:0] b;
      logic       exp_bit;
      for (int k = 0; k < 4; k++) begin
         vld_r[k] = 1'b0; dat_r[k] = 8'h00; sp[k] = 0; cyc[k] = 0; frames[k] = 0;
         done_cnt[k] = 0; start_cyc[k] = 0; period[k] = 0; lowcnt[k] = 0; lastlow[k] = 0;
         mact[k] = 1'b0; presenting[k] = 1'b0; prev_ok[k] = 1'b0; fbits[k] = '1;
      end
      forever begin
         @(negedge clk);
         cycle++;
         for (int k = 0; k < 4; k++) begin
            if (rst) begin
               mact[k] = 1'b0; vld_r[k] = 1'b0; presenting[k] = 1'b0; prev_ok[k] = 1'b0;
            end else begin
               if (!mact[k] && tx_w[k] === 1'b0) begin
                  applied++;
                  if (exp_q[k].size() == 0) begin
                     miscompares++;
                     $display("FAIL unexpected_frame dut%0d: tx went low with no byte expected", k);
                  end else begin
                     b = exp_q[k].pop_front();
                     fbits[k] = '1;
                     fbits[k][0] = 1'b0;
                     for (int i = 0; i < 8; i++) fbits[k][1+i] = b[i];
                     if (pe_of(k) != 0) fbits[k][9] = par_of(k, b);
                     mact[k] = 1'b1; cyc[k] = 0; lowcnt[k] = 0; frames[k]++;
                     period[k] = cycle - start_cyc[k]; start_cyc[k] = cycle;
                  end
               end
               if (mact[k]) begin
                  applied++;
                  if (cyc[k] < frame_len(k)) begin
                     exp_bit = fbits[k][cyc[k] / C];
                     if (tx_w[k] !== exp_bit || rdy_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL frame_cycle dut%0d cyc %0d: tx=%b rdy=%b busy=%b done=%b, wanted tx=%b rdy=0 busy=1 done=0",
                                 k, cyc[k], tx_w[k], rdy_w[k], busy_w[k], done_w[k], exp_bit);
                     end
                     if (tx_w[k] === 1'b0) lowcnt[k]++;
                     cyc[k]++;
                  end else begin
                     if (tx_w[k] !== 1'b1 || rdy_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL frame_end dut%0d: tx=%b rdy=%b busy=%b done=%b, wanted tx=1 rdy=1 busy=0 done=1",
                                 k, tx_w[k], rdy_w[k], busy_w[k], done_w[k]);
                     end
                     mact[k] = 1'b0; lastlow[k] = lowcnt[k];
                  end
               end
               if (done_w[k] === 1'b1) done_cnt[k]++;

               if (prev_ok[k]) begin
                  presenting[k] = 1'b0; sp[k]++;
               end
               if (!presenting[k] && sp[k] < stim_list.size()) begin
                  dat_r[k] = stim_list[sp[k]];
                  exp_q[k].push_back(dat_r[k]);
                  presenting[k] = 1'b1;
               end
               if (presenting[k]) begin
                  vld_r[k] = 1'b1;
               end else if (inj) begin
                  vld_r[k] = 1'b1; dat_r[k] = 8'h3C;
               end else begin
                  vld_r[k] = 1'b0; dat_r[k] = 8'($urandom);
               end
               prev_ok[k] = presenting[k] && (rdy_w[k] === 1'b1);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int  n;
      bit  idle;
      n = 0;
      do begin
         @(negedge clk); #1;
         idle = 1'b1;
         for (int k = 0; k < 4; k++)
            if (sp[k] != stim_list.size() || presenting[k] || mact[k] || exp_q[k].size() != 0) idle = 1'b0;
         n++;
      end while (!idle && n < 3000);
      applied++;
      if (!idle) begin
         miscompares++;
         $display("FAIL %s_timeout: frames still pending after %0d cycles, wanted all idle", name, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (tx_w[k] !== 1'b1 || rdy_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state dut%0d: tx=%b rdy=%b busy=%b done=%b, wanted 1 1 0 0",
                     k, tx_w[k], rdy_w[k], busy_w[k], done_w[k]);
         end
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (tx_w[k] !== 1'b1 || rdy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset dut%0d: tx=%b rdy=%b done=%b, wanted 1 1 0", k, tx_w[k], rdy_w[k], done_w[k]);
         end
      end
   endtask

   task automatic test_single(input string name, input logic [7:0] b);
      int f0 [4];
      int d0 [4];
      f0 = frames; d0 = done_cnt;
      stim_list.push_back(b);
      wait_idle(name);
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (frames[k] - f0[k] != 1) begin
            miscompares++;
            $display("FAIL %s_frames dut%0d: got %0d frames, wanted 1", name, k, frames[k] - f0[k]);
         end
         applied++;
         if (done_cnt[k] - d0[k] != 1) begin
            miscompares++;
            $display("FAIL %s_done dut%0d: got %0d tx_done pulses, wanted 1", name, k, done_cnt[k] - d0[k]);
         end
         applied++;
         if (lastlow[k] != low_expect(k, b)) begin
            miscompares++;
            $display("FAIL %s_low_cycles dut%0d: got %0d, wanted %0d", name, k, lastlow[k], low_expect(k, b));
         end
      end
   endtask

   task automatic test_back_to_back;
      int f0 [4];
      int d0 [4];
      f0 = frames; d0 = done_cnt;
      stim_list.push_back(8'h00);
      stim_list.push_back(8'hFF);
      wait_idle("b2b");
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (frames[k] - f0[k] != 2 || done_cnt[k] - d0[k] != 2) begin
            miscompares++;
            $display("FAIL b2b_count dut%0d: frames=%0d done=%0d, wanted 2 2", k, frames[k] - f0[k], done_cnt[k] - d0[k]);
         end
         applied++;
         if (period[k] != frame_len(k) + 1) begin
            miscompares++;
            $display("FAIL b2b_period dut%0d: got %0d cycles start-to-start, wanted %0d", k, period[k], frame_len(k) + 1);
         end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      int f0 [4];
      int d0 [4];
      stim_list.push_back(8'h96);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mact[0] && cyc[0] == C + 3 * C + 2) && n < 500);
      applied++;
      if (!(mact[0] && cyc[0] == C + 3 * C + 2)) begin
         miscompares++;
         $display("FAIL reach_bit3: frame position %0d, wanted %0d", cyc[0], C + 3 * C + 2);
      end
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || rdy_w[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset dut%0d: tx=%b busy=%b rdy=%b, wanted 1 0 1", k, tx_w[k], busy_w[k], rdy_w[k]);
         end
      end
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (60) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (done_cnt[k] != d0[k]) begin
            miscompares++;
            $display("FAIL abort_no_done dut%0d: got %0d tx_done pulses, wanted 0", k, done_cnt[k] - d0[k]);
         end
      end
      f0 = frames; d0 = done_cnt;
      stim_list.push_back(8'h3C);
      wait_idle("post_reset");
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (frames[k] - f0[k] != 1 || done_cnt[k] - d0[k] != 1) begin
            miscompares++;
            $display("FAIL post_reset_frame dut%0d: frames=%0d done=%0d, wanted 1 1", k, frames[k] - f0[k], done_cnt[k] - d0[k]);
         end
      end
   endtask

   task automatic test_ignore_midframe;
      int n;
      int f0 [4];
      int d0 [4];
      f0 = frames; d0 = done_cnt;
      stim_list.push_back(8'h55);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mact[0] && cyc[0] >= 10) && n < 500);
      inj = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      inj = 1'b0;
      wait_idle("midframe");
      repeat (20) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applied++;
         if (frames[k] - f0[k] != 1 || done_cnt[k] - d0[k] != 1) begin
            miscompares++;
            $display("FAIL midframe_ignored dut%0d: frames=%0d done=%0d, wanted 1 1", k, frames[k] - f0[k], done_cnt[k] - d0[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset;
      test_single("basic_a5", 8'hA5);
      test_single("parity_07", 8'h07);
      test_single("stop2_ff", 8'hFF);
      test_back_to_back;
      test_reset_mid;
      test_ignore_midframe;
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
